// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Handshake: start (sampled in IDLE) -> busy -> one-cycle done pulse with bcd_out updated.
// Optional leading-zero blank mask enabled by defining BIN2BCD_LZ_BLANK_EN;
// otherwise digit_blank is tied low.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  if (10**DIGITS <= 2**BIN_W) begin : g_param_check
    $error("bin2bcd_seq: DIGITS too small to hold 2**BIN_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     sr_adj;
  logic [SR_W-1:0]     sr_shift;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    bcd_field;

  assign bcd_field = sr[SR_W-1 -: BCD_W];

  // Add 3 to every BCD nibble >= 5, then shift the whole register left by one.
  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Control FSM with registered busy/done/bcd_out; illegal state falls back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sr      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{BCD_W{1'b0}}, bin_in};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_out <= bcd_field;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Blank digit i (i >= 1) when it and every higher digit are zero; units never blank.
  always_comb begin
    logic all_zero;
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
      all_zero = all_zero & (bcd_field[4*(DIGITS-1-j) +: 4] == 4'd0);
      blank_nxt[DIGITS-1-j] = all_zero;
    end
  end

  // Blank mask updates together with bcd_out in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_blank <= '0;
    end else if (state == S_DONE) begin
      digit_blank <= blank_nxt;
    end
  end
`else
  assign digit_blank = '0;
`endif

endmodule
